// File: rtl/sram_arb_2p.sv
// ============================================================================
// sram_arb_2p : two-requester round-robin arbiter / sequencer for a
//               single-port SRAM with fixed 2-cycle read response latency.
// Optional: SRAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_arb_2p #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [1:0]          req_we_i,
  input  logic [2*ADDR_W-1:0] req_addr_i,
  input  logic [2*DATA_W-1:0] req_wdata_i,
  output logic [1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                sram_en_o,
  output logic                sram_rw_mode_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_wr_data_o,
  input  logic [DATA_W-1:0]   sram_rd_data_i
);

  logic              prio;
  logic [1:0]        ready;
  logic [1:0]        hs;
  logic              hs_any;
  logic              hs_id;

  logic              en_q, en_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd1_vld_q, rd1_vld_d;
  logic              rd1_id_q, rd1_id_d;
  logic              rd2_vld_q, rd2_vld_d;
  logic              rd2_id_q, rd2_id_d;

  // Grant is purely combinational; nothing is granted while reset is held.
  always_comb begin
    ready = 2'b00;
    if (rst_i) begin
      if (&req_valid_i) ready = prio ? 2'b10 : 2'b01;
      else              ready = req_valid_i;
    end
  end

  assign req_ready_o = ready;
  assign hs          = req_valid_i & ready;
  assign hs_any      = |hs;
  assign hs_id       = hs[1];

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  logic prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (hs_any) prio_d = ~hs_id;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

  assign prio = prio_q;
`endif

  always_comb begin
    en_d      = hs_any;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd1_vld_d = 1'b0;
    rd1_id_d  = 1'b0;
    if (hs_any) begin
      rw_d      = req_we_i[hs_id];
      addr_d    = hs_id ? req_addr_i[ADDR_W +: ADDR_W] : req_addr_i[0 +: ADDR_W];
      wdata_d   = hs_id ? req_wdata_i[DATA_W +: DATA_W] : req_wdata_i[0 +: DATA_W];
      rd1_vld_d = ~req_we_i[hs_id];
      rd1_id_d  = hs_id;
    end
    // Second stage lines up with the cycle the SRAM presents read data.
    rd2_vld_d = rd1_vld_q;
    rd2_id_d  = rd1_id_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      en_q      <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd1_vld_q <= 1'b0;
      rd1_id_q  <= 1'b0;
      rd2_vld_q <= 1'b0;
      rd2_id_q  <= 1'b0;
    end else begin
      en_q      <= en_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd1_vld_q <= rd1_vld_d;
      rd1_id_q  <= rd1_id_d;
      rd2_vld_q <= rd2_vld_d;
      rd2_id_q  <= rd2_id_d;
    end
  end

  assign sram_en_o      = en_q;
  assign sram_rw_mode_o = rw_q;
  assign sram_addr_o    = addr_q;
  assign sram_wr_data_o = wdata_q;
  assign rsp_valid_o    = {rd2_vld_q & rd2_id_q, rd2_vld_q & ~rd2_id_q};
  assign rsp_rdata_o    = sram_rd_data_i;

endmodule

`default_nettype wire

// File: doc/sram_arb_2p.md
# sram_arb_2p

Two-requester arbiter and sequencer for the 64-bit × 256-word single-port activation/weight SRAM. It accepts read and write requests from two clients (e.g. host-load DMA and systolic-array feeder) over valid/ready handshakes, grants one per cycle, and drives a registered single access onto the SRAM. It returns read data to the originating requester with fixed latency. It sits directly between the clients and the 8-macro SRAM bank wrapper.

## Interface
- ADDR_W, 8, word address width (one address = 64 bits)
- DATA_W, 64, data width
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-low
- req_valid_i  in  2  per-requester request valid (bit n = requester n)
- req_ready_o  out  2  per-requester grant; transfer when valid & ready
- req_we_i  in  2  1 = write, 0 = read
- req_addr_i  in  2×ADDR_W  packed, requester n at [n*ADDR_W +: ADDR_W]
- req_wdata_i  in  2×DATA_W  packed write data
- rsp_valid_o  out  2  read-data valid, one-cycle pulse per accepted read
- rsp_rdata_o  out  DATA_W  read data, shared by both requesters, qualified by rsp_valid_o
- sram_en_o  out  1  SRAM chip enable (active-high)
- sram_rw_mode_o  out  1  1 = write, 0 = read
- sram_addr_o  out  ADDR_W  SRAM address
- sram_wr_data_o  out  DATA_W  SRAM write data
- sram_rd_data_i  in  DATA_W  SRAM read data, valid the cycle after a read access

## Operation
- Grant is combinational from req_valid_i and the priority pointer `prio` (1 bit); at most one req_ready_o bit is high per cycle. While rst_i = 0, req_ready_o = 0.
- Only one requester valid: it is granted that cycle.
- Both requesters valid: requester `prio` is granted.
- No handshake: pointer holds.
- After any handshake with requester n, `prio` becomes ~n (round-robin). Reset value: `prio` = 0.
- An accepted request is registered into the SRAM stage: sram_en_o = 1, and sram_rw_mode_o, sram_addr_o, sram_wr_data_o take the request fields. With no handshake, sram_en_o = 0 and the other SRAM outputs hold their last value.
- For an accepted read, the requester id is registered alongside, then shifted one more stage. rsp_valid_o[id] pulses in the cycle sram_rd_data_i is valid.
- rsp_rdata_o = sram_rd_data_i, combinational pass-through.
- Writes produce no response.
- The block has no response backpressure; requesters must sink rsp_valid_o unconditionally.
- Ordering: responses are returned in grant order. A read after a write to the same address, granted in a later cycle, returns the new data.
- A request must hold its fields stable while valid & !ready. This is required of requesters and checked by bench assertion.

## Timing
- Cycle T: handshake (req_valid_i[n] & req_ready_o[n]).
- Cycle T+1: sram_en_o = 1 with the request fields.
- Cycle T+2: read data valid on sram_rd_data_i, rsp_valid_o[n] = 1, rsp_rdata_o valid.
- Read latency is 2 cycles from handshake to response. Throughput is 1 access per cycle total.
- Back-to-back reads from alternating requesters produce consecutive rsp_valid_o pulses on alternating bits.
- Reset values: req_ready_o = 0, rsp_valid_o = 0, sram_en_o = 0, sram_rw_mode_o = 0, sram_addr_o = 0, sram_wr_data_o = 0, `prio` = 0, pipeline id/valid stages = 0.
- Reset asserted mid-operation:
  - In-flight accesses are dropped.
  - sram_en_o = 0 and rsp_valid_o = 0 from the first edge with rst_i = 0.
  - No response is produced for reads accepted before reset.

## Configuration
- SRAM_ARB_FIXED_PRIO_EN defined: `prio` is tied to 0. Requester 0 always wins when both are valid, and requester 1 is granted only when requester 0 is not valid.
- SRAM_ARB_FIXED_PRIO_EN undefined (default): round-robin as in Operation.

## Test plan
- Reset behaviour:
  - Stimulus: rst_i = 0 for 3 cycles with req_valid_i = 2'b11.
  - Required: req_ready_o = 0, sram_en_o = 0 and rsp_valid_o = 0 throughout.
  - After release, requester 0 is granted first.
- Write then read, single requester:
  - Stimulus: requester 0 writes 64'hDEAD_BEEF_0123_4567 to addr 8'h05, then reads addr 8'h05 on the next cycle.
  - Required: sram_en_o/rw_mode = 1/1 at T+1, then 1/0 at T+2.
  - Required: rsp_valid_o = 2'b01 with rsp_rdata_o = 64'hDEAD_BEEF_0123_4567 at T+3.
- Contention, round-robin:
  - Stimulus: both requesters hold reads (req0 addr 8'h10, req1 addr 8'h20) valid for 4 cycles.
  - Required: grants alternate 0,1,0,1 and rsp_valid_o alternates 01,10,01,10 with the matching preloaded data.
  - With SRAM_ARB_FIXED_PRIO_EN defined, the same stimulus yields four grants to requester 0 and none to requester 1.
- Address boundary:
  - Stimulus: requester 1 writes addr 8'hFF and 8'h00, then reads both.
  - Required: distinct data returned, with no wrap aliasing.
- Reset mid-operation:
  - Stimulus: accept a read at cycle T, assert rst_i = 0 at T+1.
  - Required: no rsp_valid_o pulse at T+2 or later; sram_en_o = 0 from T+2.
